// File: rtl/timer_control_if.sv
// Control/status bundle between the front-panel sequencer and the countdown timer.
// The sequencer side is the master; the timer side is the slave.
interface timer_control_if;
    logic       timer_enable;
    logic [1:0] timer_select;
    logic       timer_increment;
    logic       timer_clear;
    logic       timer_out;
    logic       timer_zero;

    modport master (
        output timer_enable,
        output timer_select,
        output timer_increment,
        output timer_clear,
        input  timer_out,
        input  timer_zero
    );

    modport slave (
        input  timer_enable,
        input  timer_select,
        input  timer_increment,
        input  timer_clear,
        output timer_out,
        output timer_zero
    );
endinterface

// File: rtl/timer_control.sv
// Front-panel sequencer: button edges -> timer controls, SET/RUN/PAUSE/ALARM
// mode machine, bounded buzzer drive and 2 Hz edit-field blink.
`ifndef KILO
`define KILO 1000
`endif
`ifndef SELECT_SEC
`define SELECT_SEC 2'd0
`endif
`ifndef SELECT_MIN
`define SELECT_MIN 2'd1
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd2
`endif

module timer_control #(
    parameter int unsigned CLK_FREQ_HZ   = `KILO,
    parameter int unsigned ALARM_SECONDS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_start,
    input  logic             btn_clear,
    timer_control_if.master  tif,
    output logic             alarm,
    output logic             blink_on,
    output logic [1:0]       state
);
    localparam int unsigned SW = $clog2(ALARM_SECONDS + 1);
    localparam logic [31:0] PRESC_LAST = 32'(CLK_FREQ_HZ - 1);
    localparam logic [31:0] BLINK_LAST = 32'(CLK_FREQ_HZ / 4 - 1);
    localparam logic [SW-1:0] SEC_MAX = SW'(ALARM_SECONDS);

    typedef enum logic [1:0] {
        SET   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t        state_q, state_n;
    logic [1:0]    sel_q, sel_n;
    logic          inc_q, inc_n;
    logic          clr_q, clr_n;
    logic          blink_q, blink_n;
    logic [31:0]   blink_cnt_q, blink_cnt_n;
    logic [31:0]   presc_q, presc_n;
    logic [SW-1:0] sec_q, sec_n;
    logic [3:0]    btn_prev_q;
    logic [3:0]    btn_now;
    logic [3:0]    rise;
    logic          clr_ev, start_ev, mode_ev, inc_ev;

    // bit order: clear, start, mode, inc (highest priority first)
    assign btn_now = {btn_clear, btn_start, btn_mode, btn_inc};
    assign rise    = btn_now & ~btn_prev_q;

    assign clr_ev   = rise[3];
    assign start_ev = rise[2] & ~rise[3];
    assign mode_ev  = rise[1] & ~|rise[3:2];
    assign inc_ev   = rise[0] & ~|rise[3:1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= SET;
            sel_q       <= `SELECT_SEC;
            inc_q       <= 1'b0;
            clr_q       <= 1'b0;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
            presc_q     <= '0;
            sec_q       <= '0;
            btn_prev_q  <= 4'b1111;
        end else begin
            state_q     <= state_n;
            sel_q       <= sel_n;
            inc_q       <= inc_n;
            clr_q       <= clr_n;
            blink_q     <= blink_n;
            blink_cnt_q <= blink_cnt_n;
            presc_q     <= presc_n;
            sec_q       <= sec_n;
            btn_prev_q  <= btn_now;
        end
    end

    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        inc_n   = 1'b0;
        clr_n   = 1'b0;
        if (clr_ev) begin
            state_n = SET;
            sel_n   = `SELECT_SEC;
            clr_n   = 1'b1;
        end else begin
            unique case (state_q)
                SET: begin
                    if (start_ev && !tif.timer_zero) begin
                        state_n = RUN;
                    end else if (mode_ev) begin
                        unique case (sel_q)
                            `SELECT_SEC: sel_n = `SELECT_MIN;
                            `SELECT_MIN: sel_n = `SELECT_HOUR;
                            default:     sel_n = `SELECT_SEC;
                        endcase
                    end else if (inc_ev) begin
                        inc_n = 1'b1;
                    end
                end
                RUN: begin
                    // expiry outranks a same-cycle pause request
                    if (tif.timer_out) begin
                        state_n = ALARM;
                    end else if (start_ev) begin
                        state_n = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_ev) begin
                        state_n = RUN;
                    end
                end
                ALARM: begin
                    if (start_ev) begin
                        state_n = SET;
                    end
                end
                default: state_n = SET;
            endcase
        end
    end

    always_comb begin
        presc_n = '0;
        sec_n   = '0;
        if (state_q == ALARM && state_n == ALARM) begin
            if (presc_q == PRESC_LAST) begin
                presc_n = '0;
                sec_n   = (sec_q == SEC_MAX) ? sec_q : sec_q + SW'(1);
            end else begin
                presc_n = presc_q + 32'd1;
                sec_n   = sec_q;
            end
        end
    end

    always_comb begin
        blink_n     = 1'b1;
        blink_cnt_n = '0;
        if (state_n == SET && !clr_ev && !mode_ev && !inc_ev) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_n     = ~blink_q;
                blink_cnt_n = '0;
            end else begin
                blink_n     = blink_q;
                blink_cnt_n = blink_cnt_q + 32'd1;
            end
        end
    end

    assign tif.timer_enable    = (state_q == RUN) || (state_q == ALARM);
    assign tif.timer_select    = sel_q;
    assign tif.timer_increment = inc_q;
    assign tif.timer_clear     = clr_q;
    assign alarm               = (state_q == ALARM) && (sec_q < SEC_MAX);
    assign blink_on            = blink_q;
    assign state               = state_q;
endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control with CLK_FREQ_HZ=8, ALARM_SECONDS=2.
`ifndef SELECT_SEC
`define SELECT_SEC 2'd0
`endif
`ifndef SELECT_MIN
`define SELECT_MIN 2'd1
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd2
`endif

module tb_timer_control;
    logic clk = 1'b0;
    logic reset_n;
    logic btn_mode, btn_inc, btn_start, btn_clear;
    logic alarm, blink_on;
    logic [1:0] state;
    int total = 0;
    int bad = 0;

    timer_control_if tif ();

    timer_control #(.CLK_FREQ_HZ(8), .ALARM_SECONDS(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .tif      (tif.master),
        .alarm    (alarm),
        .blink_on (blink_on),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       tout;
        logic       tzero;
        logic [1:0] st;
        logic [1:0] sel;
        logic       en;
        logic       inc;
        logic       clr;
        logic       al;
        logic       bl;
    } vec_t;

    vec_t vecs[23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_clear, btn_start, btn_mode, btn_inc} = b;
    endtask

    initial begin
        int n;
        // btn {clear,start,mode,inc}, tout, tzero -> st, sel, en, inc, clr, al, bl
        vecs[0]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{4'b0010, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        vecs[2]  = '{4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        vecs[3]  = '{4'b0010, 0, 0, 0, 2, 0, 0, 0, 0, 1};
        vecs[4]  = '{4'b0000, 0, 0, 0, 2, 0, 0, 0, 0, 1};
        vecs[5]  = '{4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[7]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{4'b0001, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        vecs[10] = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{4'b0100, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[14] = '{4'b0100, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        vecs[15] = '{4'b0000, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        vecs[16] = '{4'b0011, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        vecs[17] = '{4'b0100, 0, 0, 2, 0, 0, 0, 0, 0, 1};
        vecs[18] = '{4'b0001, 0, 0, 2, 0, 0, 0, 0, 0, 1};
        vecs[19] = '{4'b0000, 0, 0, 2, 0, 0, 0, 0, 0, 1};
        vecs[20] = '{4'b0100, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        vecs[21] = '{4'b0000, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        vecs[22] = '{4'b0000, 1, 0, 3, 0, 1, 0, 0, 1, 1};

        // reset with start held through release
        reset_n = 1'b0;
        set_btn(4'b0100);
        tif.timer_out  = 1'b0;
        tif.timer_zero = 1'b0;
        tick();
        tick();
        chk("rst_alarm", alarm, 0);
        chk("rst_clear", tif.timer_clear, 0);
        reset_n = 1'b1;
        tick();
        chk("rel_state", state, 0);
        chk("rel_sel", tif.timer_select, `SELECT_SEC);
        chk("rel_blink", blink_on, 1);
        chk("rel_en", tif.timer_enable, 0);

        for (int i = 0; i < 23; i++) begin
            set_btn(vecs[i].btn);
            tif.timer_out  = vecs[i].tout;
            tif.timer_zero = vecs[i].tzero;
            tick();
            chk($sformatf("v%0d_state", i), state, vecs[i].st);
            chk($sformatf("v%0d_sel", i), tif.timer_select, vecs[i].sel);
            chk($sformatf("v%0d_en", i), tif.timer_enable, vecs[i].en);
            chk($sformatf("v%0d_inc", i), tif.timer_increment, vecs[i].inc);
            chk($sformatf("v%0d_clr", i), tif.timer_clear, vecs[i].clr);
            chk($sformatf("v%0d_alarm", i), alarm, vecs[i].al);
            chk($sformatf("v%0d_blink", i), blink_on, vecs[i].bl);
        end

        // buzzer length: 2 s at 8 Hz = 16 cycles
        n = (alarm === 1'b1) ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            if (alarm !== 1'b1) break;
            tick();
            if (alarm === 1'b1) n++;
        end
        chk("alarm_len", n, 16);
        chk("silent_state", state, 3);
        chk("silent_en", tif.timer_enable, 1);

        // acknowledge
        set_btn(4'b0100);
        tick();
        chk("ack_state", state, 0);
        chk("ack_en", tif.timer_enable, 0);
        chk("ack_alarm", alarm, 0);
        set_btn(4'b0000);
        tif.timer_out = 1'b0;
        tick();

        // select MIN, run, then clear and start together
        set_btn(4'b0010);
        tick();
        set_btn(4'b0000);
        tick();
        set_btn(4'b0100);
        tick();
        chk("run2_state", state, 1);
        chk("run2_sel", tif.timer_select, `SELECT_MIN);
        set_btn(4'b0000);
        tick();
        set_btn(4'b1100);
        tick();
        chk("clr_pulse", tif.timer_clear, 1);
        chk("clr_state", state, 0);
        chk("clr_sel", tif.timer_select, `SELECT_SEC);
        set_btn(4'b0000);
        tick();
        chk("clr_one", tif.timer_clear, 0);
        chk("clr_hold", state, 0);

        // expiry beats a same-cycle start edge
        set_btn(4'b0100);
        tick();
        set_btn(4'b0000);
        tick();
        chk("run3_state", state, 1);
        set_btn(4'b0100);
        tif.timer_out = 1'b1;
        tick();
        chk("tout_prio", state, 3);
        set_btn(4'b0000);
        tick();
        chk("alarm_on", alarm, 1);
        reset_n = 1'b0;
        tick();
        chk("midrst_state", state, 0);
        chk("midrst_alarm", alarm, 0);
        chk("midrst_en", tif.timer_enable, 0);
        reset_n = 1'b1;
        tif.timer_out = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
